// File: rtl/time_uart_pkg.sv
// rtl/time_uart_pkg.sv - shared constants, types and ASCII helper for the time UART reporter
//
// Purpose: ASCII constants used by the record, the byte- and record-level state
// encodings, the packed digit snapshot type and the digit-to-ASCII encoder.
// Ports: none (package).
package time_uart_pkg;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_BAD   = 8'h3F;

  localparam int NUM_CHARS = 10;

  // Byte serializer states
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } byte_state_t;

  // Record-level states
  typedef enum logic {
    REC_IDLE,
    REC_SENDING
  } rec_state_t;

  // The six BCD digits as they arrive from the time counters
  typedef struct packed {
    logic [1:0] hh;
    logic [3:0] hl;
    logic [2:0] mh;
    logic [3:0] ml;
    logic [2:0] sh;
    logic [3:0] sl;
  } time_digits_t;

  // Valid BCD digits map to '0'..'9'; anything else is flagged with '?'
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    if (d > 4'd9) begin
      return CH_BAD;
    end
    return CH_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART byte serializer with per-bit cycle counter
//
// Purpose: shifts one byte out LSB first framed by one start and one stop bit.
// Every bit lasts exactly DIV cycles. A byte offered on the last stop-bit cycle
// is accepted there, so consecutive bytes run with no idle gap.
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset (line forced idle high)
//   tdata_i      byte to send
//   tvalid_i     byte offered
//   tready_o     serializer can accept tdata_i this cycle
//   byte_done_o  high on the last stop-bit cycle of the current byte
//   txd_o        serial line, registered, idle high
module uart_tx_byte
  import time_uart_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tdata_i,
  input  logic       tvalid_i,
  output logic       tready_o,
  output logic       byte_done_o,
  output logic       txd_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  byte_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_end;

  assign bit_end     = (cnt_q == CNT_LAST);
  assign byte_done_o = (state_q == STOP) && bit_end;
  // Ready on the final stop-bit cycle as well, which gives back-to-back bytes
  assign tready_o    = (state_q == IDLE) || byte_done_o;
  assign txd_o       = txd_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tvalid_i) begin
          state_d = START;
          shift_d = tdata_i;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (tvalid_i) begin
            state_d = START;
            shift_d = tdata_i;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/time_uart_tx.sv
// rtl/time_uart_tx.sv - serial reporter sending "HH:MM:SS\r\n" over UART 8N1
//
// Purpose: on SEND, snapshots the six BCD time digits and transmits the
// 10-character ASCII record through uart_tx_byte, characters back-to-back.
// Ports:
//   CLK    system clock
//   RST    asynchronous active-high reset; aborts any record in flight
//   SEND   one-cycle request, ignored while BUSY
//   HOURH, HOURL, MINH, MINL, SECH, SECL   BCD time digits
//   TXD    UART line, idle high
//   BUSY   record in progress
//   DONE   one-cycle pulse when the last stop bit has ended
module time_uart_tx
  import time_uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SEND,
  input  logic [1:0] HOURH,
  input  logic [3:0] HOURL,
  input  logic [2:0] MINH,
  input  logic [3:0] MINL,
  input  logic [2:0] SECH,
  input  logic [3:0] SECL,
  output logic       TXD,
  output logic       BUSY,
  output logic       DONE
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [3:0] LAST_IDX = 4'(NUM_CHARS - 1);

  rec_state_t   rec_q, rec_d;
  logic [3:0]   idx_q, idx_d;
  time_digits_t snap_q, snap_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  time_digits_t live;
  time_digits_t cur;
  logic [3:0]   char_sel;
  logic [7:0]   char_byte;
  logic         byte_valid;
  logic         byte_ready;
  logic         byte_done;

  assign live = '{hh: HOURH, hl: HOURL, mh: MINH, ml: MINL, sh: SECH, sl: SECL};

  assign BUSY = busy_q;
  assign DONE = done_q;

  uart_tx_byte #(
    .DIV(DIV)
  ) u_byte (
    .clk_i      (CLK),
    .rst_i      (RST),
    .tdata_i    (char_byte),
    .tvalid_i   (byte_valid),
    .tready_o   (byte_ready),
    .byte_done_o(byte_done),
    .txd_o      (TXD)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rec_q  <= REC_IDLE;
      idx_q  <= '0;
      snap_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rec_q  <= rec_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Record FSM. The next character is offered while the current one is in its
  // last stop-bit cycle, so char_sel looks one index ahead of idx_q.
  always_comb begin
    rec_d      = rec_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    byte_valid = 1'b0;
    char_sel   = idx_q + 4'd1;
    unique case (rec_q)
      REC_IDLE: begin
        if (SEND && byte_ready) begin
          byte_valid = 1'b1;
          char_sel   = '0;
          snap_d     = live;
          idx_d      = '0;
          busy_d     = 1'b1;
          rec_d      = REC_SENDING;
        end
      end
      REC_SENDING: begin
        if (byte_done) begin
          if (idx_q == LAST_IDX) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            rec_d  = REC_IDLE;
          end else begin
            byte_valid = 1'b1;
            idx_d      = char_sel;
          end
        end
      end
      default: begin
        rec_d = REC_IDLE;
      end
    endcase
  end

  // Character 0 leaves in the same cycle the snapshot is taken, so in IDLE the
  // mux reads the live digits; every later character reads the snapshot.
  always_comb begin
    cur = (rec_q == REC_IDLE) ? live : snap_q;
    unique case (char_sel)
      4'd0:    char_byte = digit_to_ascii({2'b00, cur.hh});
      4'd1:    char_byte = digit_to_ascii(cur.hl);
      4'd2:    char_byte = CH_COLON;
      4'd3:    char_byte = digit_to_ascii({1'b0, cur.mh});
      4'd4:    char_byte = digit_to_ascii(cur.ml);
      4'd5:    char_byte = CH_COLON;
      4'd6:    char_byte = digit_to_ascii({1'b0, cur.sh});
      4'd7:    char_byte = digit_to_ascii(cur.sl);
      4'd8:    char_byte = CH_CR;
      default: char_byte = CH_LF;
    endcase
  end

endmodule

// File: tb/tb_time_uart_tx.sv
// tb/tb_time_uart_tx.sv - scoreboard bench for time_uart_tx at DIV=10
module tb_time_uart_tx;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD    = 100_000;
  localparam int DIV     = 10;
  localparam int REC_CYC = 100 * DIV;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SEND;
  logic [1:0] HOURH;
  logic [3:0] HOURL;
  logic [2:0] MINH;
  logic [3:0] MINL;
  logic [2:0] SECH;
  logic [3:0] SECL;
  logic       TXD;
  logic       BUSY;
  logic       DONE;

  exp_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_want;

  time_uart_tx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .SEND (SEND),
    .HOURH(HOURH),
    .HOURL(HOURL),
    .MINH (MINH),
    .MINL (MINL),
    .SECH (SECH),
    .SECL (SECL),
    .TXD  (TXD),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                  tag, obs, obs, exp, exp, cyc);
  endtask

  function automatic logic [7:0] enc(input int d);
    return (d > 9) ? 8'h3F : 8'(8'h30 + d);
  endfunction

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic set_time(input int hh, input int hl, input int mh,
                          input int ml, input int sh, input int sl);
    HOURH = 2'(hh);
    HOURL = 4'(hl);
    MINH  = 3'(mh);
    MINL  = 4'(ml);
    SECH  = 3'(sh);
    SECL  = 4'(sl);
  endtask

  // Pulse SEND for one cycle; if the request should be accepted, push the
  // expected bytes and DONE cycle. k is the edge that samples SEND.
  task automatic send(input bit accept, output int k);
    logic [7:0] rec[10];
    exp_t e;
    SEND = 1'b1;
    k = cyc + 1;
    if (accept) begin
      rec = '{enc(int'(HOURH)), enc(int'(HOURL)), 8'h3A, enc(int'(MINH)), enc(int'(MINL)),
              8'h3A, enc(int'(SECH)), enc(int'(SECL)), 8'h0D, 8'h0A};
      for (int i = 0; i < 10; i++) begin
        e.b = rec[i];
        e.last = (i == 9);
        exp_q.push_back(e);
      end
      done_q.push_back(k + REC_CYC);
    end
    tick();
    SEND = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((BUSY || exp_q.size() != 0 || done_q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    check("drain", exp_q.size() + done_q.size(), 0);
    check("idle_busy", BUSY, 0);
    check("idle_txd", TXD, 1);
  endtask

  // UART receiver: samples mid-bit, checks framing, byte value and spacing.
  initial begin : uart_mon
    bit         prev;
    bit         abort;
    bit         sp_ok;
    int         nxt;
    int         fall;
    int         want;
    logic [9:0] frame;
    exp_t       e;
    prev  = 1'b1;
    sp_ok = 1'b0;
    nxt   = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev  = 1'b1;
        sp_ok = 1'b0;
      end else if (prev && !TXD) begin
        fall = cyc;
        if (sp_ok) check("char_gap", fall, nxt);
        abort = 1'b0;
        frame = '0;
        for (int t = 1; t <= 95 && !abort; t++) begin
          @(negedge CLK);
          if (RST) abort = 1'b1;
          else if (t % 10 == 5) frame[t / 10] = TXD;
        end
        if (abort) begin
          sp_ok = 1'b0;
          prev  = 1'b1;
        end else begin
          check("start_bit", frame[0], 0);
          check("stop_bit", frame[9], 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            want = int'(e.b);
            sp_ok = !e.last;
          end else begin
            want = -1;
            sp_ok = 1'b0;
          end
          check("rx_byte", int'(frame[8:1]), want);
          nxt  = fall + 10 * DIV;
          prev = TXD;
        end
      end else begin
        prev = TXD;
      end
    end
  end

  always @(negedge CLK) begin
    if (DONE) begin
      done_want = (done_q.size() > 0) ? done_q.pop_front() : -1;
      check("done_cyc", cyc, done_want);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int k;
    int kd;
    int nb;
    RST  = 1'b1;
    SEND = 1'b0;
    set_time(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst_txd", TXD, 1);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    RST = 1'b0;
    repeat (2) tick();
    check("post_rst_txd", TXD, 1);
    check("post_rst_busy", BUSY, 0);

    // Basic record 12:34:56
    set_time(1, 2, 3, 4, 5, 6);
    send(1'b1, k);
    wait_idle(1200);

    // Timing with 00:00:00
    set_time(0, 0, 0, 0, 0, 0);
    tick();
    check("pre_txd", TXD, 1);
    send(1'b1, k);
    check("fall_txd", TXD, 0);
    check("busy_rise", BUSY, 1);
    nb = 1;
    while (BUSY && nb < 1100) begin
      tick();
      if (BUSY) nb++;
    end
    check("busy_len", nb, REC_CYC);
    wait_idle(1200);

    // Snapshot: inputs change mid-record
    set_time(2, 3, 5, 9, 5, 9);
    send(1'b1, k);
    while (cyc < k + 200) tick();
    set_time(0, 0, 0, 0, 0, 0);
    wait_idle(1200);

    // Busy reject, then SEND on the DONE cycle
    set_time(1, 9, 0, 8, 4, 7);
    send(1'b1, k);
    while (cyc < k + 4) tick();
    send(1'b0, kd);
    while (cyc < k + 499) tick();
    send(1'b0, kd);
    while (cyc < k + REC_CYC) tick();
    check("done_at_b2b", DONE, 1);
    check("busy_at_b2b", BUSY, 0);
    set_time(2, 0, 1, 5, 3, 0);
    send(1'b1, k);
    check("b2b_fall", TXD, 0);
    check("b2b_busy", BUSY, 1);
    wait_idle(1200);

    // Invalid digit
    set_time(0, 12, 0, 0, 0, 0);
    send(1'b1, k);
    wait_idle(1200);

    // Reset mid-record
    set_time(1, 2, 3, 4, 5, 6);
    send(1'b1, k);
    while (cyc < k + 349) tick();
    RST = 1'b1;
    #1;
    check("rst_async_txd", TXD, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_txd", TXD, 1);
      check("abort_busy", BUSY, 0);
      check("abort_done", DONE, 0);
    end
    exp_q.delete();
    done_q.delete();
    RST = 1'b0;
    repeat (2) tick();
    set_time(0, 1, 0, 2, 0, 3);
    send(1'b1, k);
    wait_idle(1200);

    repeat (20) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/time_uart_tx.md
# time_uart_tx

Serial time reporter for the 24-hour clock design. On each send request it snapshots the six BCD time digits from the hour, minute and second counters. It then transmits them over a UART TX line as the 10-byte ASCII record `HH:MM:SS\r\n`, 8N1, LSB first. It sits beside the 7-segment display path as a second, off-board readout, typically triggered by the 1 Hz enable.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BAUD, 115200, line rate; bit period DIV = (CLK_HZ + BAUD/2) / BAUD cycles (434 at defaults)

Ports:
- CLK  in  1  system clock; all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- SEND  in  1  one-cycle request to start a record
- HOURH  in  2  hour tens, BCD
- HOURL  in  4  hour units, BCD
- MINH  in  3  minute tens, BCD
- MINL  in  4  minute units, BCD
- SECH  in  3  second tens, BCD
- SECL  in  4  second units, BCD
- TXD  out  1  UART line, idle high
- BUSY  out  1  record in progress
- DONE  out  1  one-cycle pulse at end of record

## Operation
- Reset values: TXD=1, BUSY=0, DONE=0, all state back to IDLE.
- Record-level FSM states: IDLE, then SENDING, indexed by char 0..9.
- In IDLE, SEND=1 latches all six digits into snapshot registers and starts char 0. The frame uses the snapshot only; later input changes do not affect the record in flight.
- Byte order and encoding:
  - Byte order: HOURH, HOURL, ':', MINH, MINL, ':', SECH, SECL, 0x0D, 0x0A.
  - Each digit d ≤ 9 is sent as 0x30+d.
  - Any digit > 9 is sent as '?' (0x3F).
- Byte-level FSM: START, DATA (bits 0..7, LSB first), STOP, one stop bit.
- Characters are sent back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
- SEND while BUSY=1 is ignored: no queueing and no restart.
- SEND in the same cycle as DONE is accepted, because the FSM is already IDLE in that cycle.
- Asserting RST mid-record aborts the record. TXD goes high at once (async) and the partial record is not resumed.

## Timing
- SEND sampled high at edge k:
  - At edge k: BUSY=1 and TXD=0 (start bit of char 0), all registered.
- Every bit lasts exactly DIV cycles, driven by a cycle counter that reloads per bit. No fractional-baud accumulation.
- Record length is 10 chars × 10 bits × DIV = 100·DIV cycles, measured from the TXD falling edge to the end of the last stop bit.
- At edge k+100·DIV:
  - BUSY=0
  - DONE=1 for exactly one cycle
  - TXD=1 (held idle)
- TXD, BUSY and DONE are driven directly from flops, with no combinational path from the inputs.

## Structure
- Package time_uart_pkg holds:
  - ASCII constants: CH_COLON 0x3A, CH_CR 0x0D, CH_LF 0x0A, CH_ZERO 0x30, CH_BAD 0x3F
  - NUM_CHARS = 10
  - byte FSM enum {IDLE, START, DATA, STOP}
  - digit-to-ASCII function
- Sub-module uart_tx_byte: the 8N1 serializer with its DIV counter.
  - Handshake is valid/ready: accepts a byte when idle, raises byte_done on its last stop-bit cycle.
  - The top level keeps the snapshot registers, the char index 0..9 and the character mux.
- Target: ~150–250 lines of RTL in total.

## Test plan
All scenarios use CLK_HZ=1_000_000 and BAUD=100_000, so DIV=10.
- Basic record: time 12:34:56, pulse SEND.
  - UART monitor receives 31 32 3A 33 34 3A 35 36 0D 0A.
  - DONE pulses exactly once, at 1000 cycles after the TXD falling edge.
- Timing: time 00:00:00.
  - TXD falls on the edge after SEND.
  - Each bit is 10 cycles; there are no idle cycles between bytes.
  - BUSY is high for exactly 1000 cycles.
- Snapshot: send 23:59:59 and change all digits to 00:00:00 at cycle 200.
  - Bytes received are 32 33 3A 35 39 3A 35 39 0D 0A.
- Busy reject and back-to-back requests:
  - Extra SEND pulses at cycles 5 and 500 are ignored; only one record and one DONE.
  - SEND on the DONE cycle starts a second full record with TXD falling on the next edge.
- Invalid digit: HOURL=4'hC, all other digits 0.
  - Byte 2 is 0x3F; all other bytes are as encoded.
- Reset mid-record: assert RST at cycle 350 for 3 cycles.
  - TXD=1, BUSY=0, DONE=0 while RST is high, and DONE never pulses for the aborted record.
  - The next SEND yields a complete, correct 10-byte record.
